// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB register slave: register offsets, FSM
// encodings, register-select indices and the byte-strobe merge helper.
package apb_reg_pkg;

    localparam logic [7:0] OFF_ID        = 8'h00;
    localparam logic [7:0] OFF_SCRATCH   = 8'h04;
    localparam logic [7:0] OFF_IRQ_PEND  = 8'h08;
    localparam logic [7:0] OFF_IRQ_MASK  = 8'h0C;
    localparam logic [7:0] OFF_STATUS    = 8'h10;
    localparam logic [7:0] OFF_CTRL_BASE = 8'h20;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    localparam logic [31:0] DEF_ID_VALUE = 32'h4150_4231;

    // One-hot register select layout; CTRL[i] sits at SEL_CTRL0+i
    localparam int MAX_CTRL    = 8;
    localparam int SEL_ID      = 0;
    localparam int SEL_SCRATCH = 1;
    localparam int SEL_PEND    = 2;
    localparam int SEL_MASK    = 3;
    localparam int SEL_STATUS  = 4;
    localparam int SEL_CTRL0   = 5;
    localparam int NUM_SEL     = SEL_CTRL0 + MAX_CTRL;

    typedef struct packed {
        logic [NUM_SEL-1:0] sel;
        logic               err;
    } dec_t;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational address decode: byte offset + direction -> one-hot register
// select and an error flag. Errors (misaligned, unmapped, write to a
// read-only register) always come with an all-zero select.
module apb_reg_decode
    import apb_reg_pkg::*;
#(
    parameter int NUM_CTRL = 4
) (
    input  logic [7:0] offset,
    input  logic       write,
    output dec_t       dec
);

    // Match the offset; anything that selects nothing is an error
    always_comb begin
        dec = '0;
        case (offset)
            OFF_ID:       dec.sel[SEL_ID]      = !write;
            OFF_SCRATCH:  dec.sel[SEL_SCRATCH] = 1'b1;
            OFF_IRQ_PEND: dec.sel[SEL_PEND]    = 1'b1;
            OFF_IRQ_MASK: dec.sel[SEL_MASK]    = 1'b1;
            OFF_STATUS:   dec.sel[SEL_STATUS]  = !write;
            default: begin
                for (int i = 0; i < NUM_CTRL; i++)
                    if (offset == OFF_CTRL_BASE + 8'(4*i))
                        dec.sel[SEL_CTRL0+i] = 1'b1;
            end
        endcase
        if (offset[1:0] != 2'b00 || dec.sel == '0) begin
            dec.sel = '0;
            dec.err = 1'b1;
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer register bank: ID, SCRATCH, STATUS, W1C interrupt
// pending/mask pair and NUM_CTRL byte-strobed CTRL registers.
// Optional macro APB_SLV_WAIT_EN inserts WAIT_CYCLES wait states per transfer.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          SELECT_WIDTH = 4,
    parameter int          NUM_CTRL     = 4,
    parameter logic [31:0] ID_VALUE     = DEF_ID_VALUE,
    parameter int          WAIT_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     apb_PSEL,
    input  logic [ADDR_WIDTH-1:0]    apb_PADDR,
    input  logic [SELECT_WIDTH-1:0]  apb_PSTRB,
    input  logic [2:0]               apb_PPROT,
    input  logic                     apb_PENABLE,
    input  logic                     apb_PWRITE,
    input  logic [DATA_WIDTH-1:0]    apb_PWDATA,
    output logic                     apb_PREADY,
    output logic [DATA_WIDTH-1:0]    apb_PRDATA,
    output logic                     apb_PSLVERROR,
    input  logic [31:0]              sts_i,
    input  logic [31:0]              irq_src_i,
    output logic [NUM_CTRL*32-1:0]   ctrl_o,
    output logic                     irq_o
);

    logic [0:0]               state;
    logic [NUM_SEL-1:0]       sel_q;
    logic [31:0]              scratch_q, pend_q, mask_q;
    logic [NUM_CTRL-1:0][31:0] ctrl_q;
    logic [31:0]              rd_mux;
    logic                     setup, commit, wr_commit;
    dec_t                     dec;

    // Upper address bits are decoded upstream; PPROT carries no meaning here
    logic unused_bits;
    assign unused_bits = ^{apb_PADDR[ADDR_WIDTH-1:8], apb_PPROT, 32'(WAIT_CYCLES)};

`ifdef APB_SLV_WAIT_EN
    localparam logic       RDY_AT_SETUP = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LD      = 4'(WAIT_CYCLES);
    logic [3:0] wcnt_q;
`else
    localparam logic       RDY_AT_SETUP = 1'b1;
`endif

    apb_reg_decode #(.NUM_CTRL(NUM_CTRL)) u_decode (
        .offset (apb_PADDR[7:0]),
        .write  (apb_PWRITE),
        .dec    (dec)
    );

    assign setup     = (state == S_IDLE) && apb_PSEL && !apb_PENABLE;
    assign commit    = (state == S_ACCESS) && apb_PSEL && apb_PENABLE && apb_PREADY;
    assign wr_commit = commit && apb_PWRITE;
    assign ctrl_o    = ctrl_q;

    // Read data is selected from the live decode and captured at setup
    always_comb begin
        rd_mux = '0;
        if (dec.sel[SEL_ID])      rd_mux = ID_VALUE;
        if (dec.sel[SEL_SCRATCH]) rd_mux = scratch_q;
        if (dec.sel[SEL_PEND])    rd_mux = pend_q;
        if (dec.sel[SEL_MASK])    rd_mux = mask_q;
        if (dec.sel[SEL_STATUS])  rd_mux = sts_i;
        for (int i = 0; i < NUM_CTRL; i++)
            if (dec.sel[SEL_CTRL0+i]) rd_mux = ctrl_q[i];
    end

    // Transfer FSM: latch decode and response at setup, complete in ACCESS
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            sel_q         <= '0;
            apb_PREADY    <= 1'b0;
            apb_PRDATA    <= '0;
            apb_PSLVERROR <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            wcnt_q        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (setup) begin
                        state         <= S_ACCESS;
                        sel_q         <= dec.sel;
                        apb_PSLVERROR <= dec.err;
                        apb_PRDATA    <= apb_PWRITE ? '0 : rd_mux;
                        apb_PREADY    <= RDY_AT_SETUP;
`ifdef APB_SLV_WAIT_EN
                        wcnt_q        <= WAIT_LD;
`endif
                    end
                end
                S_ACCESS: begin
                    // Completion and a dropped PSEL both end the transfer
                    if (!apb_PSEL || commit) begin
                        state         <= S_IDLE;
                        sel_q         <= '0;
                        apb_PREADY    <= 1'b0;
                        apb_PRDATA    <= '0;
                        apb_PSLVERROR <= 1'b0;
                    end
`ifdef APB_SLV_WAIT_EN
                    else if (!apb_PREADY) begin
                        wcnt_q <= wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) apb_PREADY <= 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RW registers update per byte lane on a committed write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scratch_q <= '0;
            mask_q    <= '0;
            ctrl_q    <= '0;
        end else if (wr_commit) begin
            if (sel_q[SEL_SCRATCH]) scratch_q <= strb_merge(scratch_q, apb_PWDATA, apb_PSTRB);
            if (sel_q[SEL_MASK])    mask_q    <= strb_merge(mask_q, apb_PWDATA, apb_PSTRB);
            for (int i = 0; i < NUM_CTRL; i++)
                if (sel_q[SEL_CTRL0+i]) ctrl_q[i] <= strb_merge(ctrl_q[i], apb_PWDATA, apb_PSTRB);
        end
    end

    // Pending bits: W1C ignoring strobes, new sources win over the clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
            irq_o  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~((wr_commit && sel_q[SEL_PEND]) ? apb_PWDATA : '0)) | irq_src_i;
            irq_o  <= |(pend_q & mask_q);
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed testbench for apb_reg_slave; each task covers one scenario.
module tb_apb_reg_slave;

    logic         clk = 1'b0;
    logic         resetn;
    logic         psel, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic         pready, pslverr, irq;
    logic [31:0]  prdata, sts, irq_src;
    logic [127:0] ctrl;

    int errors = 0;
    int checks = 0;

`ifdef APB_SLV_WAIT_EN
    localparam int WEXP = 2;
`else
    localparam int WEXP = 0;
`endif

    always #5 clk = ~clk;

    apb_reg_slave dut (
        .clk           (clk),
        .resetn        (resetn),
        .apb_PSEL      (psel),
        .apb_PADDR     (paddr),
        .apb_PSTRB     (pstrb),
        .apb_PPROT     (pprot),
        .apb_PENABLE   (penable),
        .apb_PWRITE    (pwrite),
        .apb_PWDATA    (pwdata),
        .apb_PREADY    (pready),
        .apb_PRDATA    (prdata),
        .apb_PSLVERROR (pslverr),
        .sts_i         (sts),
        .irq_src_i     (irq_src),
        .ctrl_o        (ctrl),
        .irq_o         (irq)
    );

    // Setup + access; returns once PREADY is seen, leaving PSEL/PENABLE high
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd,
                            output logic err, output int waits);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = {24'h0, addr}; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (pready !== 1'b1 && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        if (pready !== 1'b1) begin
            errors++;
            $display("FAIL pready_timeout addr=%h: got %b expected 1", addr, pready);
        end
        rd  = prdata;
        err = pslverr;
    endtask

    // Let the completion edge pass, then return the bus to idle
    task automatic apb_end();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        pstrb = 0; pprot = 0; sts = 32'hCAFE_F00D; irq_src = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        #1;
        checks++;
        if ({pready, pslverr, irq} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {pready, pslverr, irq}); end
        checks++;
        if (prdata !== 32'h0) begin errors++;
            $display("FAIL reset_prdata: got %h expected 0", prdata); end
        checks++;
        if (ctrl !== 128'h0) begin errors++;
            $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
    endtask

    task automatic test_read_id();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h4150_4231) begin errors++;
            $display("FAIL id_data: got %h expected 41504231", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL id_err: got %b expected 0", er); end
        checks++;
        if (w != WEXP) begin errors++; $display("FAIL id_waits: got %0d expected %0d", w, WEXP); end
        apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++;
            $display("FAIL status_read: got %h/%b expected cafef00d/0", rd, er); end
    endtask

    task automatic test_scratch_strobe();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101, rd, er, w); apb_end();
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL scratch_wr_err: got %b expected 0", er); end
        apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h00AD_00EF) begin errors++;
            $display("FAIL scratch_strobe: got %h expected 00ad00ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w;
        logic [7:0]  addr [4] = '{8'h14, 8'h00, 8'h02, 8'h30};
        logic        wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apb_xfer(wr[i], addr[i], 32'hFFFF_FFFF, 4'hF, rd, er, w); apb_end();
            checks++;
            if (er !== 1'b1 || rd !== 32'h0) begin errors++;
                $display("FAIL err_resp addr=%h: got err=%b data=%h expected err=1 data=0", addr[i], er, rd); end
        end
        checks++;
        if (ctrl !== 128'h0) begin errors++; $display("FAIL err_ctrl_kept: got %h expected 0", ctrl); end
        apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h00AD_00EF) begin errors++;
            $display("FAIL err_scratch_kept: got %h expected 00ad00ef", rd); end
        // Highest implemented CTRL is still mapped
        apb_xfer(1'b0, 8'h2C, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin errors++;
            $display("FAIL ctrl3_read: got %h/%b expected 0/0", rd, er); end
        // PENABLE without a setup phase is ignored
        @(posedge clk); #1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pready !== 1'b0) begin errors++; $display("FAIL idle_penable: got %b expected 0", pready); end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, 8'h0C, 32'h0000_0002, 4'hF, rd, er, w); apb_end();
        @(posedge clk); #1; irq_src = 32'h3;
        @(posedge clk); #1; irq_src = 32'h0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
        apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL pend_read: got %h expected 3", rd); end
        // W1C ignores strobes
        apb_xfer(1'b1, 8'h08, 32'h0000_0002, 4'h0, rd, er, w); apb_end();
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL pend_w1c: got %h expected 1", rd); end
        // Source pulse coincides with the W1C commit edge
        apb_xfer(1'b1, 8'h08, 32'h0000_0001, 4'hF, rd, er, w);
        irq_src = 32'h1;
        apb_end();
        irq_src = 32'h0;
        apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL pend_set_prio: got %h expected 1", rd); end
        apb_xfer(1'b1, 8'h08, 32'h0000_0001, 4'hF, rd, er, w); apb_end();
        apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL pend_clear_all: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, 8'h24, 32'h1234_5678, 4'hF, rd, er, w);
        apb_xfer(1'b0, 8'h24, 32'h0, 4'h0, rd, er, w);
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++;
            $display("FAIL b2b_read: got %h/%b expected 12345678/0", rd, er); end
        apb_end();
        checks++;
        if (ctrl !== {64'h0, 32'h1234_5678, 32'h0}) begin errors++;
            $display("FAIL b2b_ctrl_o: got %h expected ctrl[1]=12345678 only", ctrl); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready: got %b expected 0", pready); end
        checks++;
        if (ctrl !== 128'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h expected 0", ctrl); end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk); resetn = 1'b1;
        apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, er, w); apb_end();
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_scratch: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_scratch_strobe();
        test_errors();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
